aqp_spi_cmd_master: RTL and testbench

SPI master that frames and transmits one command message (command byte plus 0–8 payload bytes) and optionally captures the bytes returned on MISO. It is the initiator side of the command protocol decoded by the ESP SPI slave logic. Message framing is chip-select low, command byte, payload bytes, chip-select high. It lets on-chip logic and benches drive a command-slave instance (reset, keyboard matrix, hand controller, bus cycles, ROM writes) exactly as the ESP does.

---
 rtl/aqp_spi_cmd_master_if.sv | 36 +++
 rtl/aqp_spi_cmd_master.sv | 182 ++++++++++++++++++
 tb/tb_aqp_spi_cmd_master.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/aqp_spi_cmd_master_if.sv
// aqp_spi_cmd_master_if
// Bundles the command-side handshake and the SPI pins of aqp_spi_cmd_master.
//   master modport : the SPI master itself (takes the command, drives the bus)
//   slave modport  : whoever issues commands and plays the SPI slave
// Signals:
//   start            one-cycle request, sampled only when the master is idle
//   cmd[7:0]         command byte
//   len[3:0]         payload byte count (values above 8 act as 8)
//   payload[63:0]    payload, byte k in [8k+7:8k], sent k-th
//   busy / done      message in flight / one-cycle completion pulse
//   rx_data[63:0]    bytes returned on MISO during the payload phase
//   spi_ssel_n, spi_sclk, spi_mosi, spi_miso   SPI mode-0 pins
`timescale 1ns/1ps
interface aqp_spi_cmd_master_if;
  logic        start;
  logic [7:0]  cmd;
  logic [3:0]  len;
  logic [63:0] payload;
  logic        busy;
  logic        done;
  logic [63:0] rx_data;
  logic        spi_ssel_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    input  start, cmd, len, payload, spi_miso,
    output busy, done, rx_data, spi_ssel_n, spi_sclk, spi_mosi
  );

  modport slave (
    output start, cmd, len, payload, spi_miso,
    input  busy, done, rx_data, spi_ssel_n, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/aqp_spi_cmd_master.sv
// aqp_spi_cmd_master
// SPI mode-0 master that frames one command message: chip select low,
// command byte, 0..8 payload bytes (MSB first), chip select high.
// Optionally captures the bytes returned on MISO during the payload phase.
// Parameters:
//   CLKDIV   SPI half-period in clk_i cycles (2..255)
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous active-high reset
//   bus_io   aqp_spi_cmd_master_if.master (command handshake + SPI pins)
// Build option:
//   AQP_SPI_READBACK_EN  when defined, MISO capture and rx_data are built;
//                        otherwise rx_data is tied to zero and MISO ignored.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start, chip select high
// SETUP   | chip select low, MOSI = cmd[7], one half-period
// BIT_LO  | SCLK low, MOSI carries the current bit
// BIT_HI  | SCLK high, MISO sampled on the last cycle
// TAIL    | SCLK low after the final bit, chip select still low
// GAP     | chip select high before returning to IDLE, done at the end
`timescale 1ns/1ps
module aqp_spi_cmd_master #(
  parameter int CLKDIV = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  aqp_spi_cmd_master_if.master  bus_io
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_BIT_LO, S_BIT_HI, S_TAIL, S_GAP
  } state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLKDIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  byte_q, byte_d;
  logic [3:0]  nbytes_q, nbytes_d;
  logic [71:0] tx_q, tx_d;
  logic        div_tc;
  logic        done;
  logic        capture;
  logic [3:0]  len_clamped;
  logic [7:0]  cur_byte;

  assign div_tc      = (div_q == 8'd0);
  assign len_clamped = (bus_io.len > 4'd8) ? 4'd8 : bus_io.len;
  assign cur_byte    = tx_q[7:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      nbytes_q <= '0;
      tx_q     <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      nbytes_q <= nbytes_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_tc ? DIV_LOAD : div_q - 8'd1;
    bit_d    = bit_q;
    byte_d   = byte_q;
    nbytes_d = nbytes_q;
    tx_d     = tx_q;
    done     = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        div_d = DIV_LOAD;
        if (bus_io.start) begin
          state_d  = S_SETUP;
          tx_d     = {bus_io.payload, bus_io.cmd};
          bit_d    = 3'd7;
          byte_d   = 4'd0;
          nbytes_d = len_clamped + 4'd1;
        end
      end
      S_SETUP:  if (div_tc) state_d = S_BIT_LO;
      S_BIT_LO: if (div_tc) state_d = S_BIT_HI;
      S_BIT_HI: begin
        if (div_tc) begin
          capture = 1'b1;
          state_d = S_BIT_LO;
          if (bit_q == 3'd0) begin
            bit_d = 3'd7;
            if (byte_q + 4'd1 == nbytes_q) begin
              state_d = S_TAIL;
            end else begin
              byte_d = byte_q + 4'd1;
              tx_d   = {8'h00, tx_q[71:8]};
            end
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      S_TAIL: begin
        if (div_tc) begin
          state_d = S_GAP;
          // GAP spans two divider periods (bit counter reused as the
          // period count) so done lands at t + CLKDIV*(16N+4).
          bit_d   = 3'd1;
        end
      end
      S_GAP: begin
        if (div_tc) begin
          if (bit_q == 3'd0) begin
            state_d = S_IDLE;
            done    = 1'b1;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_io.done       = done;
  assign bus_io.busy       = (state_q != S_IDLE) && !done;
  assign bus_io.spi_sclk   = (state_q == S_BIT_HI);
  assign bus_io.spi_ssel_n = !((state_q == S_SETUP) || (state_q == S_BIT_LO) ||
                               (state_q == S_BIT_HI) || (state_q == S_TAIL));
  // bit_q only moves at the end of BIT_HI, so MOSI changes with SCLK low.
  assign bus_io.spi_mosi   = ((state_q == S_SETUP) || (state_q == S_BIT_LO) ||
                              (state_q == S_BIT_HI)) ? cur_byte[bit_q] : 1'b0;

`ifdef AQP_SPI_READBACK_EN
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [63:0] rx_q, rx_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_sh_q <= '0;
      rx_q    <= '0;
    end else begin
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
    end
  end

  always_comb begin
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    if ((state_q == S_IDLE) && bus_io.start) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < len_clamped) rx_d[8*k +: 8] = 8'h00;
      end
    end
    if (capture) begin
      rx_sh_d = {rx_sh_q[6:0], bus_io.spi_miso};
      // Byte 0 of the frame is the command; its returned byte is dropped.
      if (bit_q == 3'd0) begin
        for (int k = 0; k < 8; k++) begin
          if (byte_q == 4'(k + 1)) rx_d[8*k +: 8] = {rx_sh_q[6:0], bus_io.spi_miso};
        end
      end
    end
  end

  assign bus_io.rx_data = rx_q;
`else
  logic unused_readback;
  assign unused_readback = ^{bus_io.spi_miso, capture};
  assign bus_io.rx_data  = 64'h0;
`endif

endmodule

// File: tb/tb_aqp_spi_cmd_master.sv
`timescale 1ns/1ps
module tb_aqp_spi_cmd_master;
  localparam int C = 4;
`ifdef AQP_SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aqp_spi_cmd_master_if ifc();
  aqp_spi_cmd_master #(.CLKDIV(C)) dut (.clk_i(clk), .rst_i(rst), .bus_io(ifc.master));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- slave / bus monitor ----------------
  int          n_rise = 0, first_rise = -1, ssel_rise = -1;
  int          done_cnt = 0, mosi_bad = 0, stable_run = 0;
  logic        prev_sclk = 1'b0, prev_ssel = 1'b1, last_mosi = 1'b0, held_mosi = 1'b0;
  logic [71:0] cap_frame = '0;
  logic [71:0] miso_frame = '0;

  always @(negedge clk) begin
    if (ifc.spi_mosi === last_mosi) stable_run++;
    else stable_run = 1;
    last_mosi = ifc.spi_mosi;
    if (ifc.done === 1'b1) done_cnt++;
    if (ifc.spi_ssel_n !== 1'b0) begin
      if (prev_ssel == 1'b0) ssel_rise = cyc;
      if (ifc.spi_sclk !== 1'b0) mosi_bad++;
      ifc.spi_miso = 1'b0;
    end else begin
      if (prev_ssel == 1'b1) begin
        n_rise = 0; first_rise = -1; ssel_rise = -1; cap_frame = '0;
      end
      if (ifc.spi_sclk === 1'b1 && prev_sclk == 1'b0) begin
        if (n_rise == 0) first_rise = cyc;
        if (stable_run < C + 1) mosi_bad++;
        if (n_rise < 72) cap_frame[8*(n_rise/8) + 7 - (n_rise%8)] = ifc.spi_mosi;
        held_mosi = ifc.spi_mosi;
        n_rise++;
      end else if (ifc.spi_sclk === 1'b1 && ifc.spi_mosi !== held_mosi) begin
        mosi_bad++;
      end
      if (ifc.spi_sclk === 1'b0)
        ifc.spi_miso = (n_rise < 72) ? miso_frame[8*(n_rise/8) + 7 - (n_rise%8)] : 1'b0;
    end
    prev_sclk = ifc.spi_sclk;
    prev_ssel = ifc.spi_ssel_n;
  end

  // ---------------- reference model ----------------
  logic [7:0] rx_m [8];

  function automatic int clamp_len(input logic [3:0] l);
    return (l > 4'd8) ? 8 : int'(l);
  endfunction

  function automatic logic [71:0] model_frame(input logic [7:0] c, input logic [3:0] l,
                                              input logic [63:0] p);
    logic [71:0] f;
    int n;
    n = clamp_len(l);
    f = '0;
    f[7:0] = c;
    for (int k = 0; k < 8; k++) if (k < n) f[8*(k+1) +: 8] = p[8*k +: 8];
    return f;
  endfunction

  function automatic logic [63:0] model_rx();
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = RB ? rx_m[k] : 8'h00;
    return r;
  endfunction

  task automatic run_msg(input string tag, input logic [7:0] c, input logic [3:0] l,
                         input logic [63:0] p, input logic [71:0] mf,
                         input int exp_pulses, input int exp_done,
                         input int restart_at, input bit start_on_done);
    int t0, done_t, dc0, bad0, n;
    bit seen;
    logic [71:0] ef;
    n  = clamp_len(l);
    ef = model_frame(c, l, p);
    @(negedge clk);
    miso_frame = mf;
    ifc.cmd = c; ifc.len = l; ifc.payload = p; ifc.start = 1'b1;
    t0 = cyc; dc0 = done_cnt; bad0 = mosi_bad;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.cmd = ~c; ifc.payload = ~p; ifc.len = 4'($urandom);
    check({tag, "_accept"}, 72'({ifc.busy, ifc.spi_ssel_n}), 72'(2'b10));
    seen = 1'b0; done_t = -1;
    for (int i = 1; i < 4000 && !seen; i++) begin
      @(negedge clk);
      ifc.start = (i == restart_at);
      if (ifc.done === 1'b1) begin
        seen = 1'b1; done_t = cyc;
        if (start_on_done) ifc.start = 1'b1;
      end
    end
    @(negedge clk);
    ifc.start = 1'b0;
    if (start_on_done)
      check({tag, "_start_on_done_ignored"}, 72'({ifc.busy, ifc.spi_ssel_n}), 72'(2'b01));
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) if (k < n) rx_m[k] = mf[8*(k+1) +: 8];
    check({tag, "_pulses"},     72'(n_rise), 72'(exp_pulses));
    check({tag, "_mosi_frame"}, cap_frame, ef);
    check({tag, "_first_rise"}, 72'(first_rise - t0), 72'(1 + 2*C));
    check({tag, "_done_time"},  72'(done_t - t0), 72'(exp_done));
    check({tag, "_ssel_rise"},  72'(ssel_rise - t0), 72'(exp_done - 2*C + 1));
    check({tag, "_done_count"}, 72'(done_cnt - dc0), 72'(1));
    check({tag, "_mosi_timing"}, 72'(mosi_bad - bad0), 72'(0));
    check({tag, "_rx_data"},    72'(ifc.rx_data), 72'(model_rx()));
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [63:0] payload;
    logic [71:0] miso;
    int          exp_pulses;
    int          exp_done;
    int          restart_at;
    bit          start_on_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int dc0;
    logic [7:0]  rc;
    logic [3:0]  rl;
    logic [63:0] rp;
    logic [71:0] rm;
    int rn;

    vecs[0] = '{8'h01, 4'd0,  64'h0,                   72'hFF,                            8,  80,   0, 1'b0};
    vecs[1] = '{8'h10, 4'd8,  64'h0123456789ABCDEF,    72'h5566778899AABBCCDD,            72, 592,  0, 1'b1};
    vecs[2] = '{8'h23, 4'd2,  64'hFFFFFFFFFFFFFFFF,    {48'h0, 8'h3C, 8'hA5, 8'h99},      24, 208,  0, 1'b0};
    vecs[3] = '{8'hC3, 4'd12, 64'h8877665544332211,    72'h0F1E2D3C4B5A697887,            72, 592,  200, 1'b0};
    vecs[4] = '{8'h5A, 4'd1,  64'h000000000000007E,    72'h000000000000008100,            16, 144,  0, 1'b1};

    for (int k = 0; k < 8; k++) rx_m[k] = 8'h00;
    ifc.start = 1'b0; ifc.cmd = '0; ifc.len = '0; ifc.payload = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 72'({ifc.spi_ssel_n, ifc.spi_sclk, ifc.spi_mosi, ifc.busy, ifc.done}),
          72'(5'b10000));
    check("reset_rx_data", 72'(ifc.rx_data), 72'(0));
    rst = 1'b0;

    dc0 = done_cnt;
    repeat (100) @(negedge clk);
    check("idle_outputs", 72'({ifc.spi_ssel_n, ifc.spi_sclk, ifc.busy}), 72'(3'b100));
    check("idle_no_done", 72'(done_cnt - dc0), 72'(0));

    for (int v = 0; v < 5; v++)
      run_msg($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].len, vecs[v].payload, vecs[v].miso,
              vecs[v].exp_pulses, vecs[v].exp_done, vecs[v].restart_at, vecs[v].start_on_done);

    // reset during bit 3 of payload byte 1 (21st SCLK rising edge)
    @(negedge clk);
    miso_frame = 72'h123456789ABCDEF012;
    ifc.cmd = 8'hA7; ifc.len = 4'd3; ifc.payload = 64'h00000000_00C0FFEE; ifc.start = 1'b1;
    dc0 = done_cnt;
    @(negedge clk);
    ifc.start = 1'b0;
    for (int i = 0; i < 2000 && n_rise < 21; i++) @(negedge clk);
    check("rst_mid_reached_bit", 72'({n_rise[7:0], ifc.spi_sclk}), 72'({8'd21, 1'b1}));
    #2 rst = 1'b1;
    #1;
    check("rst_mid_async_outputs", 72'({ifc.spi_ssel_n, ifc.spi_sclk, ifc.busy, ifc.done}),
          72'(4'b1000));
    for (int k = 0; k < 8; k++) rx_m[k] = 8'h00;
    check("rst_mid_rx_cleared", 72'(ifc.rx_data), 72'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", 72'(done_cnt - dc0), 72'(0));
    run_msg("after_rst", vecs[1].cmd, vecs[1].len, vecs[1].payload, vecs[1].miso,
            vecs[1].exp_pulses, vecs[1].exp_done, 0, 1'b0);

    // randomized messages against the model
    for (int r = 0; r < 6; r++) begin
      rc = 8'($urandom);
      rl = 4'($urandom_range(0, 15));
      rp = {$urandom, $urandom};
      rm = {8'($urandom), $urandom, $urandom};
      rn = clamp_len(rl) + 1;
      run_msg($sformatf("rand%0d", r), rc, rl, rp, rm, 8*rn, C*(4 + 16*rn),
              (r == 2) ? 50 : 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
